// File: rtl/conv2_pkg.sv
// Shared constants, state type and window bit mapping for the conv2 frame sequencer.
package conv2_pkg;

  localparam int unsigned IMG_W    = 13;
  localparam int unsigned IMG_H    = 13;
  localparam int unsigned IN_CH    = 8;
  localparam int unsigned OUT_CH   = 16;
  localparam int unsigned K        = 3;
  localparam int unsigned WIN_BITS = K * K * IN_CH;
  localparam int unsigned N_OUT    = (IMG_W - 2) * (IMG_H - 2);
  localparam int unsigned N_PIX    = IMG_W * IMG_H;
  localparam int unsigned COL_W    = $clog2(IMG_W);
  localparam int unsigned ROW_W    = $clog2(IMG_H);
  localparam int unsigned CNT_W    = $clog2(N_OUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  function automatic int unsigned win_idx(input int unsigned ch, input int unsigned r,
                                          input int unsigned c);
    return ch * K * K + r * K + c;
  endfunction

endpackage

// File: rtl/conv2_line_buf.sv
// Shift-on-enable delay line: o_data is the sample pushed Depth enables ago.
module conv2_line_buf
  import conv2_pkg::*;
#(
  parameter int unsigned Depth = IMG_W,
  parameter int unsigned Width = IN_CH
) (
  input  logic             i_clk,
  input  logic             i_en,
  input  logic [Width-1:0] i_data,
  output logic [Width-1:0] o_data
);

  logic [Width-1:0] r_mem [Depth];

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_mem[0] <= i_data;
      for (int unsigned i = 1; i < Depth; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  assign o_data = r_mem[Depth-1];

endmodule

// File: rtl/conv2_sched.sv
// conv2 frame sequencer: raster pixels in, 3x3x8 windows to the datapath, registered results out.
module conv2_sched
  import conv2_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_frame_done,
  input  logic [IN_CH-1:0]    i_in_pixel,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  output logic [WIN_BITS-1:0] o_win_data,
  output logic                o_win_valid,
  input  logic [OUT_CH-1:0]   i_calc_out,
  input  logic                i_calc_valid,
  output logic [OUT_CH-1:0]   o_out_data,
  output logic                o_out_valid,
  input  logic                i_out_ready
);

  state_e              r_state, w_state_next;
  logic [ROW_W-1:0]    r_in_row;
  logic [COL_W-1:0]    r_in_col;
  logic [CNT_W-1:0]    r_out_count;
  logic [WIN_BITS-1:0] r_win_data, w_win_next;
  logic                r_win_valid, r_out_valid;
  logic [OUT_CH-1:0]   r_out_data;
  logic [IN_CH-1:0]    r_arr [K][K-1];
  logic [IN_CH-1:0]    w_cols [K][K];
  logic [IN_CH-1:0]    w_lb1, w_lb2;
  logic                w_adv_o, w_in_ready, w_accept, w_qual, w_last_pix, w_out_hs, w_last_res;

  assign w_adv_o    = !r_out_valid || i_out_ready;
  assign w_in_ready = (r_state == RUN) && w_adv_o;
  assign w_accept   = i_in_valid && w_in_ready;
  assign w_qual     = w_accept && (r_in_row >= ROW_W'(2)) && (r_in_col >= COL_W'(2));
  assign w_last_pix = (r_in_row == ROW_W'(IMG_H - 1)) && (r_in_col == COL_W'(IMG_W - 1));
  assign w_out_hs   = r_out_valid && i_out_ready;
  assign w_last_res = (r_state == DRAIN) && w_out_hs && (r_out_count == CNT_W'(N_OUT - 1));

  conv2_line_buf #(.Depth(IMG_W), .Width(IN_CH)) u_lb1 (
    .i_clk  (i_clk),
    .i_en   (w_accept),
    .i_data (i_in_pixel),
    .o_data (w_lb1)
  );

  conv2_line_buf #(.Depth(IMG_W), .Width(IN_CH)) u_lb2 (
    .i_clk  (i_clk),
    .i_en   (w_accept),
    .i_data (w_lb1),
    .o_data (w_lb2)
  );

  // Rightmost window column is the incoming column; r_arr keeps the two columns to its left.
  always_comb begin
    for (int unsigned r = 0; r < K; r++) begin
      w_cols[r][0] = r_arr[r][0];
      w_cols[r][1] = r_arr[r][1];
    end
    w_cols[0][2] = w_lb2;
    w_cols[1][2] = w_lb1;
    w_cols[2][2] = i_in_pixel;
  end

  always_comb begin
    w_win_next = '0;
    for (int unsigned ch = 0; ch < IN_CH; ch++) begin
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned c = 0; c < K; c++) begin
          w_win_next[win_idx(ch, r, c)] = w_cols[r][c][ch];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      for (int unsigned r = 0; r < K; r++) begin
        r_arr[r][0] <= r_arr[r][1];
        r_arr[r][1] <= w_cols[r][2];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (i_start) w_state_next = RUN;
      RUN:     if (w_accept && w_last_pix) w_state_next = DRAIN;
      DRAIN:   if (w_last_res) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    o_busy       = (r_state != IDLE);
    o_in_ready   = w_in_ready;
    o_frame_done = w_last_res;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_in_row    <= '0;
      r_in_col    <= '0;
      r_out_count <= '0;
    end else begin
      if (r_state == IDLE && i_start) begin
        r_in_row    <= '0;
        r_in_col    <= '0;
        r_out_count <= '0;
      end else begin
        if (w_accept) begin
          if (r_in_col == COL_W'(IMG_W - 1)) begin
            r_in_col <= '0;
            r_in_row <= w_last_pix ? '0 : r_in_row + ROW_W'(1);
          end else begin
            r_in_col <= r_in_col + COL_W'(1);
          end
        end
        if (w_last_res) begin
          r_out_count <= '0;
        end else if (w_out_hs) begin
          r_out_count <= r_out_count + CNT_W'(1);
        end
      end
    end
  end

  // Both stages move only when the output stage can advance, so stalls never drop results.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_win_valid <= 1'b0;
      r_win_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_adv_o) begin
      r_win_valid <= w_qual;
      if (w_qual) r_win_data <= w_win_next;
      r_out_valid <= r_win_valid;
      if (r_win_valid) r_out_data <= i_calc_out;
    end
  end

  assign o_win_data  = r_win_data;
  assign o_win_valid = r_win_valid;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;

  a_calc_valid: assert property (@(posedge i_clk) disable iff (i_rst)
                                 i_calc_valid == r_win_valid);

endmodule

// File: tb/tb_conv2_sched.sv
// Bench for conv2_sched: frame-level table of scenarios checked against an image-based model.
module tb_conv2_sched;
  import conv2_pkg::*;

  logic                clk = 1'b0;
  logic                rst, start, in_valid, out_ready, calc_valid;
  logic [IN_CH-1:0]    in_pixel;
  logic [OUT_CH-1:0]   calc_out, out_data;
  logic [WIN_BITS-1:0] win_data;
  logic                busy, frame_done, in_ready, win_valid, out_valid;

  int n_chk  = 0;
  int n_pass = 0;

  logic [IN_CH-1:0]    img [N_PIX];
  logic [WIN_BITS-1:0] exp_win [$];
  logic [OUT_CH-1:0]   exp_res [$];

  always #5 clk = ~clk;

  conv2_sched dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .o_busy       (busy),
    .o_frame_done (frame_done),
    .i_in_pixel   (in_pixel),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .o_win_data   (win_data),
    .o_win_valid  (win_valid),
    .i_calc_out   (calc_out),
    .i_calc_valid (calc_valid),
    .o_out_data   (out_data),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready)
  );

  // Datapath stand-in: output channel o is 1 when more than 36 of 72 XNOR bits match its weights.
  function automatic logic [OUT_CH-1:0] dp(input logic [WIN_BITS-1:0] w);
    logic [OUT_CH-1:0] res;
    int pc;
    for (int o = 0; o < OUT_CH; o++) begin
      pc = 0;
      for (int b = 0; b < WIN_BITS; b++) pc += int'(w[b] == (((b * 7 + o * 13) % 5) < 2));
      res[o] = (pc > 36);
    end
    return res;
  endfunction

  assign calc_out   = dp(win_data);
  assign calc_valid = win_valid;

  function automatic logic [WIN_BITS-1:0] ref_win(input int r, input int c);
    logic [WIN_BITS-1:0] w;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        for (int ch = 0; ch < IN_CH; ch++)
          w[ch * 9 + rr * 3 + cc] = img[(r - 2 + rr) * IMG_W + (c - 2 + cc)][ch];
    return w;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_frame_done"}, 128'(frame_done), 128'(0));
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(0));
    chk({tag, "_win_valid"}, 128'(win_valid), 128'(0));
    chk({tag, "_win_data"}, 128'(win_data), 128'(0));
    chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_out_data"}, 128'(out_data), 128'(0));
  endtask

  // Runs one frame (or stops after stop_after accepted pixels when stop_after > 0).
  task automatic run_frame(input int pat, input int stall, input bit spam, input int stop_after,
                           output int n_res, output int n_done);
    int idx, wi, oi, acc28, first_out;
    bit acc, stalled_prev;
    logic [OUT_CH-1:0] prev_data;
    for (int i = 0; i < N_PIX; i++)
      img[i] = (pat == 0) ? IN_CH'(i % 256) : (pat == 1) ? 8'hA5 : IN_CH'($urandom);
    exp_win.delete();
    exp_res.delete();
    for (int r = 2; r < IMG_H; r++)
      for (int c = 2; c < IMG_W; c++) begin
        exp_win.push_back(ref_win(r, c));
        exp_res.push_back(dp(ref_win(r, c)));
      end
    idx = 0; wi = 0; oi = 0; n_done = 0; acc28 = -1; first_out = -1; stalled_prev = 0;
    prev_data = '0;
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b1; in_pixel = img[0];
    out_ready = (stall == 0) ? 1'b1 : ($urandom_range(99) >= stall);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (cyc == 0) chk("busy_before_start_edge", 128'(busy), 128'(0));
      if (cyc == 1) chk("busy_after_start", 128'(busy), 128'(1));
      acc = in_valid && in_ready;
      if (acc && idx == 28) acc28 = cyc;
      if (out_valid && first_out < 0) first_out = cyc;
      if (stalled_prev) begin
        chk("stall_out_valid_held", 128'(out_valid), 128'(1));
        chk("stall_out_data_held", 128'(out_data), 128'(prev_data));
      end
      if (out_valid && !out_ready) chk("in_ready_low_in_stall", 128'(in_ready), 128'(0));
      stalled_prev = out_valid && !out_ready;
      prev_data = out_data;
      if (win_valid && (!out_valid || out_ready)) begin
        chk("win_in_range", 128'(wi < N_OUT), 128'(1));
        if (wi < N_OUT) chk($sformatf("win_%0d", wi), 128'(win_data), 128'(exp_win[wi]));
        wi++;
      end
      if (out_valid && out_ready) begin
        chk("res_in_range", 128'(oi < N_OUT), 128'(1));
        if (oi < N_OUT) chk($sformatf("res_%0d", oi), 128'(out_data), 128'(exp_res[oi]));
        oi++;
      end
      if (frame_done) begin
        n_done++;
        chk("done_on_last_result", 128'(oi), 128'(N_OUT));
        break;
      end
      @(posedge clk); #1;
      start = spam && cyc >= 2 && ((cyc % 7 == 3) || (idx >= N_PIX && cyc % 2 == 0));
      if (acc) idx++;
      if (stop_after > 0 && idx == stop_after) break;
      in_valid = (idx < N_PIX) && ((pat != 2) || ($urandom_range(3) != 0));
      in_pixel = (idx < N_PIX) ? img[idx] : '0;
      out_ready = (stall == 0) ? 1'b1 : ($urandom_range(99) >= stall);
    end
    start = 1'b0;
    n_res = oi;
    if (stop_after == 0) begin
      in_valid = 1'b0;
      if (stall == 0) chk("first_beat_latency", 128'(first_out), 128'(acc28 + 2));
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("idle_busy", 128'(busy), 128'(0));
        chk("idle_out_valid", 128'(out_valid), 128'(0));
        chk("idle_no_done", 128'(frame_done), 128'(0));
      end
    end
  endtask

  typedef struct {
    string name;
    int    pat;
    int    stall;
    bit    spam;
    int    exp_res;
    int    exp_done;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int n_res, n_done;
    vecs[0] = '{"ramp",        0, 0,  1'b0, N_OUT, 1};
    vecs[1] = '{"const_a5",    1, 0,  1'b0, N_OUT, 1};
    vecs[2] = '{"rand_stall",  2, 50, 1'b0, N_OUT, 1};
    vecs[3] = '{"start_spam",  2, 50, 1'b1, N_OUT, 1};
    vecs[4] = '{"ramp_spam",   0, 0,  1'b1, N_OUT, 1};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b1;
    #12;
    chk_reset_vals("por");
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v].pat, vecs[v].stall, vecs[v].spam, 0, n_res, n_done);
      chk({vecs[v].name, "_results"}, 128'(n_res), 128'(vecs[v].exp_res));
      chk({vecs[v].name, "_frame_done"}, 128'(n_done), 128'(vecs[v].exp_done));
    end

    // Abort after pixel 60, then a clean frame must still come out whole.
    run_frame(0, 0, 1'b0, 61, n_res, n_done);
    chk("abort_no_done", 128'(n_done), 128'(0));
    #2 rst = 1'b1;
    #1 chk_reset_vals("midrst");
    in_valid = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst_hold");
    rst = 1'b0;
    run_frame(0, 25, 1'b0, 0, n_res, n_done);
    chk("after_rst_results", 128'(n_res), 128'(N_OUT));
    chk("after_rst_frame_done", 128'(n_done), 128'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
